vfu_result_arbiter: RTL

Shares one VRF write port between the lane's ALU and MFPU result channels. Both units raise result requests independently. This block buffers one result per source, arbitrates with MFPU priority plus an ALU starvation override, and drives a single registered request toward the VRF arbiter. It sits between `vector_fus_stage` result outputs and the lane's operand/VRF arbitration.

---
 rtl/vfu_result_arbiter_pkg.sv | 24 ++
 rtl/vfu_result_arbiter_chk.sv | 37 +++
 rtl/vfu_result_buffer.sv | 51 +++++
 rtl/vfu_result_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vfu_result_arbiter_pkg.sv
// Shared types for the VFU result arbiter slice.
// Provides the element/instruction-id types, the result source enum, the
// default starvation limit and a saturating counter helper.
package vfu_result_arbiter_pkg;

  localparam int unsigned ELEN    = 64;
  localparam int unsigned NrVInsn = 8;

  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic {
    VfuSrcAlu  = 1'b0,
    VfuSrcMfpu = 1'b1
  } vfu_src_e;

  localparam int unsigned VfuStarveLimit = 4;

  // Increment by one, but never past lim.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? lim : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/vfu_result_arbiter_chk.sv
// Assertion checker for vfu_result_arbiter.
// Ports:
//   clk_i, rst_i  : clock and synchronous reset of the arbiter
//   vrf_req_i     : registered VRF request
//   vrf_gnt_i     : VRF accept
//   vrf_src_i     : registered source tag
//   payload_i     : registered payload, flattened
module vfu_result_arbiter_chk #(
  parameter int unsigned NrLanes      = 0,
  parameter int unsigned StarveLimit  = 4,
  parameter int unsigned PayloadWidth = 1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  input logic                    vrf_req_i,
  input logic                    vrf_gnt_i,
  input logic                    vrf_src_i,
  input logic [PayloadWidth-1:0] payload_i
);

  // A stalled request must keep its payload, source and request bit.
  a_payload_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (vrf_req_i && !vrf_gnt_i && !rst_i) |=>
        ($stable(payload_i) && $stable(vrf_src_i) && vrf_req_i)
  ) else $error("vfu_result_arbiter: payload changed while stalled");

  a_starve_limit: assert property (
    @(posedge clk_i) (StarveLimit >= 32'd1) && (StarveLimit <= 32'd15)
  ) else $error("vfu_result_arbiter: StarveLimit %0d out of range", StarveLimit);

  a_nr_lanes: assert property (
    @(posedge clk_i) (NrLanes == 32'd0) ||
                     ((NrLanes <= 32'd16) && ((NrLanes & (NrLanes - 32'd1)) == 32'd0))
  ) else $error("vfu_result_arbiter: unsupported NrLanes %0d", NrLanes);

endmodule

// File: rtl/vfu_result_buffer.sv
// One-entry result holding buffer.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   capture_i     : load data_i into the entry (wins over pop_i)
//   pop_i         : entry consumed by the output register this cycle
//   data_i        : incoming payload
//   valid_o       : entry holds a result
//   data_o        : stored payload
module vfu_result_buffer #(
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     capture_i,
  input  logic     pop_i,
  input  payload_t data_i,
  output logic     valid_o,
  output payload_t data_o
);

  logic     valid_q, valid_d;
  payload_t data_q, data_d;

  // Capture during a pop keeps the entry full with the new payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/vfu_result_arbiter.sv
// Shares one VRF write port between the ALU and MFPU result channels.
// Each source has a one-entry holding buffer; a registered output stage
// picks MFPU first, except that the ALU wins once it has lost StarveLimit
// consecutive load slots.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   alu_result_*_i / _gnt_o   : ALU result request, payload, accept pulse
//   mfpu_result_*_i / _gnt_o  : MFPU result request, payload, accept pulse
//   vrf_req_o, vrf_*_o        : registered write request and payload
//   vrf_src_o                 : 0 = ALU, 1 = MFPU
//   vrf_gnt_i                 : VRF accepts the current request
//   alu_starved_o             : starvation counter sits at StarveLimit
module vfu_result_arbiter
  import vfu_result_arbiter_pkg::*;
#(
  parameter int unsigned NrLanes     = 0,
  parameter type         vaddr_t     = logic,
  parameter int unsigned StarveLimit = VfuStarveLimit,
  localparam int unsigned DataWidth  = $bits(elen_t),
  localparam type         strb_t     = logic [DataWidth/8-1:0]
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   alu_result_req_i,
  input  vid_t   alu_result_id_i,
  input  vaddr_t alu_result_addr_i,
  input  elen_t  alu_result_wdata_i,
  input  strb_t  alu_result_be_i,
  output logic   alu_result_gnt_o,
  input  logic   mfpu_result_req_i,
  input  vid_t   mfpu_result_id_i,
  input  vaddr_t mfpu_result_addr_i,
  input  elen_t  mfpu_result_wdata_i,
  input  strb_t  mfpu_result_be_i,
  output logic   mfpu_result_gnt_o,
  output logic   vrf_req_o,
  output vid_t   vrf_id_o,
  output vaddr_t vrf_addr_o,
  output elen_t  vrf_wdata_o,
  output strb_t  vrf_be_o,
  output logic   vrf_src_o,
  input  logic   vrf_gnt_i,
  output logic   alu_starved_o
);

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } payload_t;

  localparam logic [3:0] Limit = 4'(StarveLimit);

  payload_t alu_in, mfpu_in, alu_buf, mfpu_buf;
  logic     alu_valid, mfpu_valid;
  logic     load, starved, sel_alu, alu_pop, mfpu_pop;

  payload_t   out_q, out_d;
  logic       vrf_req_q, vrf_req_d;
  vfu_src_e   src_q, src_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign alu_in  = '{id: alu_result_id_i, addr: alu_result_addr_i,
                     wdata: alu_result_wdata_i, be: alu_result_be_i};
  assign mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                     wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

  vfu_result_buffer #(.payload_t(payload_t)) i_alu_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .capture_i(alu_result_gnt_o),
    .pop_i    (alu_pop),
    .data_i   (alu_in),
    .valid_o  (alu_valid),
    .data_o   (alu_buf)
  );

  vfu_result_buffer #(.payload_t(payload_t)) i_mfpu_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .capture_i(mfpu_result_gnt_o),
    .pop_i    (mfpu_pop),
    .data_i   (mfpu_in),
    .valid_o  (mfpu_valid),
    .data_o   (mfpu_buf)
  );

  // Arbitration: MFPU first unless the ALU has been starved long enough.
  always_comb begin
    starved  = (starve_cnt_q == Limit);
    load     = (~vrf_req_q | vrf_gnt_i) & (alu_valid | mfpu_valid);
    sel_alu  = alu_valid & (~mfpu_valid | starved);
    alu_pop  = load & sel_alu;
    mfpu_pop = load & ~sel_alu;
  end

  // A buffer accepts when empty or being drained in the same cycle.
  assign alu_result_gnt_o  = alu_result_req_i  & (~alu_valid  | alu_pop)  & ~rst_i;
  assign mfpu_result_gnt_o = mfpu_result_req_i & (~mfpu_valid | mfpu_pop) & ~rst_i;

  // Output register and starvation counter next state.
  always_comb begin
    vrf_req_d    = vrf_req_q;
    out_d        = out_q;
    src_d        = src_q;
    starve_cnt_d = starve_cnt_q;

    if (load) begin
      vrf_req_d = 1'b1;
      if (sel_alu) begin
        out_d = alu_buf;
        src_d = VfuSrcAlu;
      end else begin
        out_d = mfpu_buf;
        src_d = VfuSrcMfpu;
      end
    end else if (vrf_gnt_i) begin
      // Granted with nothing buffered behind it.
      vrf_req_d = 1'b0;
    end else begin
      vrf_req_d = vrf_req_q;
    end

    if (~alu_valid || alu_pop) begin
      starve_cnt_d = 4'd0;
    end else if (load) begin
      // ALU waiting but MFPU took the slot.
      starve_cnt_d = sat_inc(starve_cnt_q, Limit);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vrf_req_q    <= 1'b0;
      out_q        <= '0;
      src_q        <= VfuSrcAlu;
      starve_cnt_q <= 4'd0;
    end else begin
      vrf_req_q    <= vrf_req_d;
      out_q        <= out_d;
      src_q        <= src_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign vrf_req_o     = vrf_req_q;
  assign vrf_id_o      = out_q.id;
  assign vrf_addr_o    = out_q.addr;
  assign vrf_wdata_o   = out_q.wdata;
  assign vrf_be_o      = out_q.be;
  assign vrf_src_o     = src_q;
  assign alu_starved_o = starved;

  vfu_result_arbiter_chk #(
    .NrLanes     (NrLanes),
    .StarveLimit (StarveLimit),
    .PayloadWidth($bits(payload_t))
  ) i_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .vrf_req_i(vrf_req_q),
    .vrf_gnt_i(vrf_gnt_i),
    .vrf_src_i(src_q),
    .payload_i(out_q)
  );

endmodule
